sseg_scan_ctrl: RTL and testbench

- Time-multiplexes one 8-bit seven-segment output bus among four hex digits, so a 4-digit common-anode display can show four 4-bit counter values, e.g. from cascaded hex counter stages.
- Owns the scan divider, the digit-select ring, leading-zero blanking and per-digit decimal points.
- Sits between the counter datapath and the board display pins.

---
 rtl/sseg_pkg.sv | 49 ++++
 rtl/hex_to_sseg.sv | 13 +
 rtl/sseg_scan_ctrl.sv | 119 +++++++++++
 tb/tb_sseg_scan_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types, glyph table and helpers for the seven-segment scan controller.
package sseg_pkg;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } digit_idx_e;

   typedef struct packed {
      logic [3:0] hex;
      logic       dp;
      logic       blank;
   } digit_sel_t;

   localparam logic [7:0] SEG_OFF   = 8'hFF;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [3:0] ANODE_OFF = 4'b1111;

   localparam logic [3:0] ANODE_SEL [4] = '{
      4'b1110, 4'b1101, 4'b1011, 4'b0111
   };

   // Active-low {g,f,e,d,c,b,a}, indexed by hex value
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned scan_hz);
      return clk_hz / scan_hz;
   endfunction

   function automatic digit_idx_e next_idx(input digit_idx_e idx);
      digit_idx_e nxt;
      case (idx)
         DIG0:    nxt = DIG1;
         DIG1:    nxt = DIG2;
         DIG2:    nxt = DIG3;
         default: nxt = DIG0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex-to-glyph decoder, active-low a-g.
module hex_to_sseg
   import sseg_pkg::*;
(
   input  logic [3:0] iHex,
   output logic [6:0] oSeg
);

   always_comb begin
      oSeg = GLYPH[iHex];
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver with scan divider,
// leading-zero blanking and per-digit decimal points.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned SCAN_HZ = 1_000
) (
   input  logic        iClk,
   input  logic        iReset,
   input  logic [15:0] iDigits,
   input  logic [3:0]  iDP,
   input  logic        iBlank_en,
   input  logic        iScan_en,
   output logic [7:0]  oSSeg,
   output logic [3:0]  oAnode,
   output logic        oScan_tick
);

   localparam int unsigned DIV   = calc_div(CLK_HZ, SCAN_HZ);
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   digit_idx_e       idx_q, idx_d;
   logic             tick_q, tick_d;
   logic [3:0]       anode_q, anode_d;
   logic [7:0]       sseg_q, sseg_d;

   logic [3:0]       zero;
   logic [3:1]       blank_mask;
   digit_sel_t       sel;
   logic [6:0]       glyph;

   // A digit blanks only when it and every digit above it are zero
   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         zero[k] = (iDigits[4*k +: 4] == 4'h0);
      end
      blank_mask[3] = iBlank_en & zero[3];
      blank_mask[2] = blank_mask[3] & zero[2];
      blank_mask[1] = blank_mask[2] & zero[1];
   end

   always_comb begin
      div_d  = div_q;
      idx_d  = idx_q;
      tick_d = 1'b0;
      if (iScan_en) begin
         if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
            idx_d  = next_idx(idx_q);
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   always_comb begin
      sel.hex   = iDigits[3:0];
      sel.dp    = iDP[0];
      sel.blank = 1'b0;
      case (idx_d)
         DIG1: begin
            sel.hex   = iDigits[7:4];
            sel.dp    = iDP[1];
            sel.blank = blank_mask[1];
         end
         DIG2: begin
            sel.hex   = iDigits[11:8];
            sel.dp    = iDP[2];
            sel.blank = blank_mask[2];
         end
         DIG3: begin
            sel.hex   = iDigits[15:12];
            sel.dp    = iDP[3];
            sel.blank = blank_mask[3];
         end
         default: ;
      endcase
   end

   hex_to_sseg u_dec (
      .iHex (sel.hex),
      .oSeg (glyph)
   );

   // Outputs only reload on a tick so the display is frozen between ticks
   always_comb begin
      anode_d = anode_q;
      sseg_d  = sseg_q;
      if (tick_d) begin
         anode_d = ANODE_SEL[idx_d];
         sseg_d  = {~sel.dp, sel.blank ? SEG_BLANK : glyph};
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         div_q   <= '0;
         idx_q   <= DIG3;
         tick_q  <= 1'b0;
         anode_q <= ANODE_OFF;
         sseg_q  <= SEG_OFF;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         anode_q <= anode_d;
         sseg_q  <= sseg_d;
      end
   end

   assign oSSeg      = sseg_q;
   assign oAnode     = anode_q;
   assign oScan_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed self-checking bench for sseg_scan_ctrl at DIV = 4.
module tb_sseg_scan_ctrl;

   logic        iClk;
   logic        iReset;
   logic [15:0] iDigits;
   logic [3:0]  iDP;
   logic        iBlank_en;
   logic        iScan_en;
   logic [7:0]  oSSeg;
   logic [3:0]  oAnode;
   logic        oScan_tick;

   int unsigned checks;
   int unsigned errors;

   sseg_scan_ctrl #(
      .CLK_HZ  (40),
      .SCAN_HZ (10)
   ) dut (
      .iClk       (iClk),
      .iReset     (iReset),
      .iDigits    (iDigits),
      .iDP        (iDP),
      .iBlank_en  (iBlank_en),
      .iScan_en   (iScan_en),
      .oSSeg      (oSSeg),
      .oAnode     (oAnode),
      .oScan_tick (oScan_tick)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic apply_reset();
      iReset = 1'b1;
      step();
      step();
      iReset = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] an_e [4];
      logic [7:0] sg_e [4];
      an_e = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      sg_e = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
      iDigits = 16'h1234; iDP = 4'h0; iBlank_en = 1'b0; iScan_en = 1'b1;
      iReset = 1'b1;
      step();
      step();
      checks++;
      if (oAnode !== 4'b1111 || oSSeg !== 8'hFF || oScan_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got an=%b seg=%h tick=%b expected an=1111 seg=ff tick=0",
                  oAnode, oSSeg, oScan_tick);
      end
      iReset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (oAnode !== 4'b1111 || oScan_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_dark c%0d: got an=%b tick=%b expected an=1111 tick=0",
                     i, oAnode, oScan_tick);
         end
      end
      for (int d = 0; d < 5; d++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (oAnode !== an_e[d%4] || oSSeg !== sg_e[d%4] || oScan_tick !== (c == 0)) begin
               errors++;
               $display("FAIL scan d%0d c%0d: got an=%b seg=%h tick=%b expected an=%b seg=%h tick=%b",
                        d, c, oAnode, oSSeg, oScan_tick, an_e[d%4], sg_e[d%4], (c == 0));
            end
         end
      end
   endtask

   task automatic test_blank();
      iDigits = 16'h0050; iDP = 4'h0; iBlank_en = 1'b1; iScan_en = 1'b1;
      apply_reset();
      repeat (4) step();
      checks++;
      if (oAnode !== 4'b1110 || oSSeg !== 8'hC0) begin
         errors++;
         $display("FAIL blank_d0: got an=%b seg=%h expected an=1110 seg=c0", oAnode, oSSeg);
      end
      repeat (4) step();
      checks++;
      if (oAnode !== 4'b1101 || oSSeg !== 8'h92) begin
         errors++;
         $display("FAIL blank_d1: got an=%b seg=%h expected an=1101 seg=92", oAnode, oSSeg);
      end
      repeat (4) step();
      checks++;
      if (oAnode !== 4'b1011 || oSSeg !== 8'hFF) begin
         errors++;
         $display("FAIL blank_d2: got an=%b seg=%h expected an=1011 seg=ff", oAnode, oSSeg);
      end
      iBlank_en = 1'b0;
      step();
      checks++;
      if (oSSeg !== 8'hFF) begin
         errors++;
         $display("FAIL blank_toggle_hold: got seg=%h expected seg=ff", oSSeg);
      end
      repeat (3) step();
      checks++;
      if (oAnode !== 4'b0111 || oSSeg !== 8'hC0) begin
         errors++;
         $display("FAIL unblank_d3: got an=%b seg=%h expected an=0111 seg=c0", oAnode, oSSeg);
      end
   endtask

   task automatic test_all_zero();
      logic [7:0] sg_e [4];
      sg_e = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
      iDigits = 16'h0000; iDP = 4'h0; iBlank_en = 1'b1; iScan_en = 1'b1;
      apply_reset();
      repeat (3) step();
      for (int d = 0; d < 4; d++) begin
         repeat (4) step();
         checks++;
         if (oSSeg !== sg_e[d]) begin
            errors++;
            $display("FAIL zero_d%0d: got seg=%h expected seg=%h", d, oSSeg, sg_e[d]);
         end
      end
   endtask

   task automatic test_scan_hold();
      iDigits = 16'h1234; iDP = 4'h0; iBlank_en = 1'b0; iScan_en = 1'b1;
      apply_reset();
      repeat (4) step();
      repeat (2) step();
      iScan_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (oAnode !== 4'b1110 || oScan_tick !== 1'b0) begin
            errors++;
            $display("FAIL hold c%0d: got an=%b tick=%b expected an=1110 tick=0",
                     i, oAnode, oScan_tick);
         end
      end
      iScan_en = 1'b1;
      step();
      checks++;
      if (oAnode !== 4'b1110 || oScan_tick !== 1'b0) begin
         errors++;
         $display("FAIL hold_resume: got an=%b tick=%b expected an=1110 tick=0", oAnode, oScan_tick);
      end
      step();
      checks++;
      if (oAnode !== 4'b1101 || oSSeg !== 8'hB0 || oScan_tick !== 1'b1) begin
         errors++;
         $display("FAIL hold_tick: got an=%b seg=%h tick=%b expected an=1101 seg=b0 tick=1",
                  oAnode, oSSeg, oScan_tick);
      end
      // divider now 0 on digit 1; reach DIV-1 then disable on that cycle
      repeat (3) step();
      iScan_en = 1'b0;
      repeat (2) step();
      checks++;
      if (oAnode !== 4'b1101 || oScan_tick !== 1'b0) begin
         errors++;
         $display("FAIL hold_last: got an=%b tick=%b expected an=1101 tick=0", oAnode, oScan_tick);
      end
      iScan_en = 1'b1;
      step();
      checks++;
      if (oAnode !== 4'b1011 || oSSeg !== 8'hA4 || oScan_tick !== 1'b1) begin
         errors++;
         $display("FAIL hold_last_tick: got an=%b seg=%h tick=%b expected an=1011 seg=a4 tick=1",
                  oAnode, oSSeg, oScan_tick);
      end
   endtask

   task automatic test_dp();
      logic [7:0] sg_e [4];
      sg_e = '{8'h0E, 8'h8E, 8'h0E, 8'h8E};
      iDigits = 16'hFFFF; iDP = 4'b0101; iBlank_en = 1'b1; iScan_en = 1'b1;
      apply_reset();
      repeat (3) step();
      for (int d = 0; d < 4; d++) begin
         repeat (4) step();
         checks++;
         if (oSSeg !== sg_e[d]) begin
            errors++;
            $display("FAIL dp_d%0d: got seg=%h expected seg=%h", d, oSSeg, sg_e[d]);
         end
      end
   endtask

   task automatic test_input_change();
      iDigits = 16'h0008; iDP = 4'h0; iBlank_en = 1'b0; iScan_en = 1'b1;
      apply_reset();
      repeat (4) step();
      checks++;
      if (oAnode !== 4'b1110 || oSSeg !== 8'h80) begin
         errors++;
         $display("FAIL chg_first: got an=%b seg=%h expected an=1110 seg=80", oAnode, oSSeg);
      end
      step();
      iDigits = 16'h0003;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (oSSeg !== 8'h80) begin
            errors++;
            $display("FAIL chg_stable c%0d: got seg=%h expected seg=80", i, oSSeg);
         end
      end
      repeat (13) step();
      checks++;
      if (oAnode !== 4'b1110 || oSSeg !== 8'hB0) begin
         errors++;
         $display("FAIL chg_revisit: got an=%b seg=%h expected an=1110 seg=b0", oAnode, oSSeg);
      end
      // value presented on the edge that ticks must be the one shown
      repeat (15) step();
      iDigits = 16'h0006;
      step();
      checks++;
      if (oAnode !== 4'b1110 || oSSeg !== 8'h82) begin
         errors++;
         $display("FAIL chg_on_tick: got an=%b seg=%h expected an=1110 seg=82", oAnode, oSSeg);
      end
   endtask

   task automatic test_reset_mid();
      iDigits = 16'h1234; iDP = 4'h0; iBlank_en = 1'b0; iScan_en = 1'b1;
      apply_reset();
      repeat (12) step();
      step();
      checks++;
      if (oAnode !== 4'b1011) begin
         errors++;
         $display("FAIL mid_pre: got an=%b expected an=1011", oAnode);
      end
      iReset = 1'b1;
      step();
      checks++;
      if (oAnode !== 4'b1111 || oSSeg !== 8'hFF || oScan_tick !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got an=%b seg=%h tick=%b expected an=1111 seg=ff tick=0",
                  oAnode, oSSeg, oScan_tick);
      end
      iReset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (oAnode !== 4'b1111 || oScan_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_dark c%0d: got an=%b tick=%b expected an=1111 tick=0",
                     i, oAnode, oScan_tick);
         end
      end
      step();
      checks++;
      if (oAnode !== 4'b1110 || oSSeg !== 8'h99 || oScan_tick !== 1'b1) begin
         errors++;
         $display("FAIL mid_restart: got an=%b seg=%h tick=%b expected an=1110 seg=99 tick=1",
                  oAnode, oSSeg, oScan_tick);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      iReset    = 1'b1;
      iDigits   = 16'h0000;
      iDP       = 4'h0;
      iBlank_en = 1'b0;
      iScan_en  = 1'b1;
      test_reset();
      test_blank();
      test_all_zero();
      test_scan_hold();
      test_dp();
      test_input_change();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
